// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one SRAM-like bus,
// tracking accepted transactions in an owner FIFO so responses can be routed back.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] OUT_CNT  = 3'(OUTSTANDING);
    localparam logic [1:0] LAST_PTR = 2'(OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t      state_q, state_d;
    logic        hold_wr_q, hold_wr_d;
    logic [1:0]  hold_size_q, hold_size_d;
    logic [3:0]  hold_wstrb_q, hold_wstrb_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic        hold_disc_q, hold_disc_d;

    // FIFO storage is sized for the largest legal depth; only OUTSTANDING slots are used.
    logic [3:0]  owner_q, owner_d;
    logic [3:0]  discard_q, discard_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;

    logic        grant_inst, grant_data;
    logic        sel_wr;
    logic [1:0]  sel_size;
    logic [3:0]  sel_wstrb;
    logic [31:0] sel_addr, sel_wdata;
    logic        push, push_disc, pop, head_owner, head_disc;

    always_comb begin
        state_d      = state_q;
        hold_wr_d    = hold_wr_q;
        hold_size_d  = hold_size_q;
        hold_wstrb_d = hold_wstrb_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_disc_d  = hold_disc_q;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        sel_wr       = 1'b0;
        sel_size     = 2'd0;
        sel_wstrb    = 4'd0;
        sel_addr     = 32'd0;
        sel_wdata    = 32'd0;
        case (state_q)
            IDLE: begin
                if (count_q < OUT_CNT) begin
                    if (data_req) begin
                        grant_data = 1'b1;
                        sel_wr     = data_wr;
                        sel_size   = data_size;
                        sel_wstrb  = data_wstrb;
                        sel_addr   = data_addr;
                        sel_wdata  = data_wdata;
                    end else if (inst_req) begin
                        grant_inst = 1'b1;
                        sel_size   = 2'd2;
                        sel_addr   = inst_addr;
                    end
                end
                if ((grant_data || grant_inst) && !bus_addr_ok) begin
                    state_d      = grant_data ? HOLD_D : HOLD_I;
                    hold_wr_d    = sel_wr;
                    hold_size_d  = sel_size;
                    hold_wstrb_d = sel_wstrb;
                    hold_addr_d  = sel_addr;
                    hold_wdata_d = sel_wdata;
                    hold_disc_d  = grant_inst && inst_cancel;
                end
            end
            HOLD_I, HOLD_D: begin
                grant_inst  = (state_q == HOLD_I);
                grant_data  = (state_q == HOLD_D);
                sel_wr      = hold_wr_q;
                sel_size    = hold_size_q;
                sel_wstrb   = hold_wstrb_q;
                sel_addr    = hold_addr_q;
                sel_wdata   = hold_wdata_q;
                // A flushed fetch still has to finish its address phase on the bus.
                hold_disc_d = hold_disc_q | (grant_inst & inst_cancel);
                if (bus_addr_ok) begin
                    state_d     = IDLE;
                    hold_disc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push       = (grant_inst | grant_data) & bus_addr_ok;
    assign push_disc  = grant_inst & (inst_cancel | hold_disc_q);
    assign pop        = bus_data_ok && (count_q != 3'd0);
    assign head_owner = owner_q[rd_ptr_q];
    assign head_disc  = discard_q[rd_ptr_q] | inst_cancel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            assign owner_d[gi]   = (push && wr_ptr_q == 2'(gi)) ? grant_data : owner_q[gi];
            assign discard_d[gi] = (push && wr_ptr_q == 2'(gi)) ? push_disc
                                 : (discard_q[gi] | (inst_cancel & ~owner_q[gi]));
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? 2'd0 : wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 2'd0 : rd_ptr_q + 2'd1;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'd0;
        bus_wstrb    = 4'd0;
        bus_addr     = 32'd0;
        bus_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        if (!reset) begin
            bus_req      = grant_inst | grant_data;
            bus_wr       = sel_wr;
            bus_size     = sel_size;
            bus_wstrb    = sel_wstrb;
            bus_addr     = sel_addr;
            bus_wdata    = sel_wdata;
            inst_addr_ok = push & grant_inst & ~((state_q == HOLD_I) & push_disc);
            data_addr_ok = push & grant_data;
            inst_data_ok = pop & ~head_owner & ~head_disc;
            data_data_ok = pop & head_owner;
            inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
            data_rdata   = data_data_ok ? bus_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_wr_q    <= 1'b0;
            hold_size_q  <= 2'd0;
            hold_wstrb_q <= 4'd0;
            hold_addr_q  <= 32'd0;
            hold_wdata_q <= 32'd0;
            hold_disc_q  <= 1'b0;
            owner_q      <= 4'd0;
            discard_q    <= 4'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            hold_wr_q    <= hold_wr_d;
            hold_size_q  <= hold_size_d;
            hold_wstrb_q <= hold_wstrb_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_disc_q  <= hold_disc_d;
            owner_q      <= owner_d;
            discard_q    <= discard_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed vectors plus randomized traffic checked against a queue-based model of the arbiter.
module tb_mem_req_arbiter;

    localparam int OUT = 2;
    localparam logic [31:0] IA = 32'h1FC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int total = 0;
    int bad   = 0;
    int vnum  = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        rst, ireq, dreq, dwr, aok, dok, cancel;
        logic        ebreq, eiaok, edaok, eidok, eddok;
        logic [31:0] eaddr;
        logic        ewr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, ireq, dreq, dwr, aok, dok, cancel,
                                input logic ebreq, eiaok, edaok, eidok, eddok,
                                input logic [31:0] eaddr, input logic ewr);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwr = dwr;
        v.aok = aok; v.dok = dok; v.cancel = cancel;
        v.ebreq = ebreq; v.eiaok = eiaok; v.edaok = edaok; v.eidok = eidok; v.eddok = eddok;
        v.eaddr = eaddr; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset       = v.rst;
        inst_req    = v.ireq;
        inst_addr   = IA;
        inst_cancel = v.cancel;
        data_req    = v.dreq;
        data_wr     = v.dwr;
        data_size   = 2'd2;
        data_wstrb  = v.dwr ? 4'hF : 4'h0;
        data_addr   = DA;
        data_wdata  = 32'hDEAD_BEEF;
        bus_addr_ok = v.aok;
        bus_data_ok = v.dok;
        bus_rdata   = 32'h5A00_0000 + 32'(vnum);
        #1;
        chk1({tag, ".bus_req"}, bus_req, v.ebreq);
        chk1({tag, ".inst_addr_ok"}, inst_addr_ok, v.eiaok);
        chk1({tag, ".data_addr_ok"}, data_addr_ok, v.edaok);
        chk1({tag, ".inst_data_ok"}, inst_data_ok, v.eidok);
        chk1({tag, ".data_data_ok"}, data_data_ok, v.eddok);
        if (v.ebreq || v.rst) begin
            chk32({tag, ".bus_addr"}, bus_addr, v.eaddr);
            chk1({tag, ".bus_wr"}, bus_wr, v.ewr);
        end
        if (v.eidok || v.rst) chk32({tag, ".inst_rdata"}, inst_rdata, v.rst ? 32'd0 : bus_rdata);
        if (v.eddok || v.rst) chk32({tag, ".data_rdata"}, data_rdata, v.rst ? 32'd0 : bus_rdata);
        $display("vec %0d %s: bus_req=%b addr=%h iaok=%b daok=%b idok=%b ddok=%b",
                 vnum, tag, bus_req, bus_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
        vnum++;
    endtask

    // Reference model state: what is being held on the bus and what is in flight.
    int          held;      // 0 none, 1 fetch, 2 data
    logic        h_wr;
    logic [1:0]  h_size;
    logic [3:0]  h_wstrb;
    logic [31:0] h_addr, h_wdata;
    bit          h_disc;
    bit          q_owner[$];
    bit          q_disc[$];

    task automatic random_cycle();
        int          win;
        logic        e_wr, acc, pdisc, pop, e_iaok, e_daok, e_idok, e_ddok;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        reset       = ($urandom_range(0, 149) == 0);
        inst_req    = $urandom_range(0, 1) == 1;
        inst_addr   = $urandom;
        inst_cancel = ($urandom_range(0, 9) == 0);
        data_req    = $urandom_range(0, 2) == 0;
        data_wr     = $urandom_range(0, 1) == 1;
        data_size   = 2'($urandom_range(0, 2));
        data_wstrb  = 4'($urandom);
        data_addr   = $urandom;
        data_wdata  = $urandom;
        bus_addr_ok = $urandom_range(0, 4) < 3;
        bus_data_ok = $urandom_range(0, 1) == 1;
        bus_rdata   = $urandom;
        #1;
        win = 0; e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
        if (!reset) begin
            if (held != 0) begin
                win = held; e_wr = h_wr; e_size = h_size; e_wstrb = h_wstrb;
                e_addr = h_addr; e_wdata = h_wdata;
            end else if (q_owner.size() < OUT) begin
                if (data_req) begin
                    win = 2; e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb;
                    e_addr = data_addr; e_wdata = data_wdata;
                end else if (inst_req) begin
                    win = 1; e_size = 2'd2; e_addr = inst_addr;
                end
            end
        end
        acc    = (win != 0) && bus_addr_ok;
        pdisc  = (win == 1) && (inst_cancel || (held == 1 && h_disc));
        e_iaok = acc && win == 1 && !(held == 1 && pdisc);
        e_daok = acc && win == 2;
        pop    = !reset && bus_data_ok && q_owner.size() > 0;
        e_ddok = pop && q_owner[0];
        e_idok = pop && !q_owner[0] && !(q_disc[0] || inst_cancel);

        chk1("rnd.bus_req", bus_req, win != 0);
        chk1("rnd.inst_addr_ok", inst_addr_ok, e_iaok);
        chk1("rnd.data_addr_ok", data_addr_ok, e_daok);
        chk1("rnd.inst_data_ok", inst_data_ok, e_idok);
        chk1("rnd.data_data_ok", data_data_ok, e_ddok);
        if (win != 0) begin
            chk32("rnd.bus_addr", bus_addr, e_addr);
            chk1("rnd.bus_wr", bus_wr, e_wr);
            chk32("rnd.bus_size", 32'(bus_size), 32'(e_size));
            chk32("rnd.bus_wstrb", 32'(bus_wstrb), 32'(e_wstrb));
            chk32("rnd.bus_wdata", bus_wdata, e_wdata);
        end
        if (e_idok) chk32("rnd.inst_rdata", inst_rdata, bus_rdata);
        if (e_ddok) chk32("rnd.data_rdata", data_rdata, bus_rdata);

        if (reset) begin
            held = 0; h_disc = 0; q_owner.delete(); q_disc.delete();
        end else begin
            if (pop) begin
                void'(q_owner.pop_front());
                void'(q_disc.pop_front());
            end
            if (inst_cancel)
                for (int i = 0; i < q_owner.size(); i++)
                    if (!q_owner[i]) q_disc[i] = 1;
            if (acc) begin
                q_owner.push_back(win == 2);
                q_disc.push_back(pdisc);
                held = 0; h_disc = 0;
            end else if (win != 0 && held == 0) begin
                held = win; h_wr = e_wr; h_size = e_size; h_wstrb = e_wstrb;
                h_addr = e_addr; h_wdata = e_wdata; h_disc = (win == 1) && inst_cancel;
            end else if (held == 1 && inst_cancel) begin
                h_disc = 1;
            end
        end
    endtask

    initial begin
        // Arbitration priority, full-FIFO back-pressure and in-order return.
        tbl.push_back(mk(1,1,1,0,1,1,0, 0,0,0,0,0, 32'd0,0));
        tbl.push_back(mk(0,1,1,0,1,0,0, 1,0,1,0,0, DA,0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 1,1,0,0,0, IA,0));
        tbl.push_back(mk(0,1,1,0,1,0,0, 0,0,0,0,0, 32'd0,0));
        tbl.push_back(mk(0,0,1,0,1,1,0, 0,0,0,0,1, 32'd0,0));
        tbl.push_back(mk(0,0,1,0,1,1,0, 1,0,1,1,0, DA,0));
        tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,1, 32'd0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,0, 32'd0,0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Store held for three cycles while a fetch waits.
        apply(mk(0,0,1,1,0,0,0, 1,0,0,0,0, DA,1), "hold_d0");
        apply(mk(0,1,0,0,0,0,0, 1,0,0,0,0, DA,1), "hold_d1");
        apply(mk(0,1,0,0,0,0,0, 1,0,0,0,0, DA,1), "hold_d2");
        apply(mk(0,1,0,0,1,0,0, 1,0,1,0,0, DA,1), "hold_d_acc");
        apply(mk(0,1,0,0,1,0,0, 1,1,0,0,0, IA,0), "hold_i_acc");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,1, 32'd0,0), "hold_ret_d");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,1,0, 32'd0,0), "hold_ret_i");

        // Two fetches flushed while in flight.
        apply(mk(0,1,0,0,1,0,0, 1,1,0,0,0, IA,0), "cxl_f0");
        apply(mk(0,1,0,0,1,0,0, 1,1,0,0,0, IA,0), "cxl_f1");
        apply(mk(0,0,0,0,0,0,1, 0,0,0,0,0, 32'd0,0), "cxl_flush");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,0, 32'd0,0), "cxl_r0");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,0, 32'd0,0), "cxl_r1");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,0, 32'd0,0), "cxl_empty");
        apply(mk(0,0,1,0,1,0,0, 1,0,1,0,0, DA,0), "cxl_d");
        apply(mk(0,1,0,0,1,0,0, 1,1,0,0,0, IA,0), "cxl_i");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,1, 32'd0,0), "cxl_rd");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,1,0, 32'd0,0), "cxl_ri");

        // Reset with a transaction outstanding.
        apply(mk(0,0,1,0,1,0,0, 1,0,1,0,0, DA,0), "rst_d");
        apply(mk(1,1,1,0,1,1,0, 0,0,0,0,0, 32'd0,0), "rst_mid");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,0, 32'd0,0), "rst_stale");
        apply(mk(0,1,1,0,0,0,0, 1,0,0,0,0, DA,0), "rst_arb");
        apply(mk(0,0,0,0,1,0,0, 1,0,1,0,0, DA,0), "rst_acc");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,1, 32'd0,0), "rst_ret");

        // Flush while a fetch is held waiting for the bus.
        apply(mk(0,1,0,0,0,0,0, 1,0,0,0,0, IA,0), "hc_hold");
        apply(mk(0,0,0,0,0,0,1, 1,0,0,0,0, IA,0), "hc_cancel");
        apply(mk(0,0,0,0,1,0,0, 1,0,0,0,0, IA,0), "hc_acc");
        apply(mk(0,0,1,0,1,0,0, 1,0,1,0,0, DA,0), "hc_d");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,0, 32'd0,0), "hc_drop");
        apply(mk(0,0,0,0,0,1,0, 0,0,0,0,1, 32'd0,0), "hc_rd");

        // Randomized traffic against the model, starting from a clean reset.
        apply(mk(1,0,0,0,0,0,0, 0,0,0,0,0, 32'd0,0), "rnd_reset");
        held = 0; h_disc = 0; h_wr = 0; h_size = 0; h_wstrb = 0; h_addr = 0; h_wdata = 0;
        q_owner.delete(); q_disc.delete();
        for (int n = 0; n < 3000; n++) random_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
